// File: rtl/clkswitch_req_ctrl.sv
// clkswitch_req_ctrl: low-speed-domain requester driving hsclk_sel into the CPU clock switch.
// Optional watchdog enabled by defining CLKSW_TIMEOUT_EN.
module clkswitch_req_ctrl #(
  parameter int unsigned LS_HOLD = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       lsclk_in,
  input  logic       rst_b,
  input  logic       hs_req,
  input  logic       force_ls,
  input  logic       lsclk_selected,
  input  logic       hsclk_selected,
  output logic       hsclk_sel,
  output logic       switching,
  output logic       in_hs,
  output logic [7:0] sw_count,
  output logic       timeout_err
);
  typedef enum logic [1:0] {LS_RUN, REQ_HS, HS_RUN, REQ_LS} state_t;
  state_t state, state_nxt;
  logic [7:0] hold, hold_dec;
  logic [1:0] sync;
  logic hs_ack, tmo;
  if (LS_HOLD > 255 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_chk
    $error("clkswitch_req_ctrl: parameter out of range");
  end
  assign hs_ack = sync[1];
  // Counting the decremented value lets the request leave on the LS_HOLD-th edge after entry.
  assign hold_dec = hold == 8'd0 ? 8'd0 : hold - 8'd1;
`ifdef CLKSW_TIMEOUT_EN
  logic [7:0] timer, timer_inc;
  logic in_req;
  assign in_req = state == REQ_HS || state == REQ_LS;
  assign timer_inc = timer == 8'hff ? 8'hff : timer + 8'd1;
  assign tmo = in_req && timer_inc == 8'(TIMEOUT);
  always_ff @(posedge lsclk_in or negedge rst_b)
    if (!rst_b) begin
      timer <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      timer <= state_nxt != state ? 8'd0 : in_req ? timer_inc : timer;
      timeout_err <= timeout_err | tmo;
    end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge lsclk_in or negedge rst_b)
    if (!rst_b) begin
      state <= LS_RUN;
      hold <= 8'(LS_HOLD);
      sync <= 2'b00;
      sw_count <= 8'd0;
    end else begin
      state <= state_nxt;
      hold <= state == LS_RUN ? hold_dec : 8'(LS_HOLD);
      sync <= {sync[0], hsclk_selected};
      sw_count <= sw_count + 8'(state == REQ_HS && state_nxt == HS_RUN);
    end
  always_comb begin
    state_nxt = state;
    case (state)
      LS_RUN: state_nxt = hs_req && !force_ls && hold_dec == 8'd0 && lsclk_selected ? REQ_HS : LS_RUN;
      REQ_HS: state_nxt = force_ls || !hs_req || tmo ? REQ_LS : hs_ack ? HS_RUN : REQ_HS;
      HS_RUN: state_nxt = force_ls || !hs_req || !hs_ack ? REQ_LS : HS_RUN;
      REQ_LS: state_nxt = lsclk_selected && !hs_ack ? LS_RUN : REQ_LS;
    endcase
  end
  always_comb begin
    hsclk_sel = state == REQ_HS || state == HS_RUN;
    switching = state == REQ_HS || state == REQ_LS;
    in_hs = state == HS_RUN;
  end
endmodule

// File: tb/tb_clkswitch_req_ctrl.sv
// tb_clkswitch_req_ctrl: directed checks of the clock-switch requester handshake.
module tb_clkswitch_req_ctrl;
  logic lsclk_in = 1'b0, rst_b, hs_req, force_ls, lsclk_selected, hsclk_selected;
  logic hsclk_sel, switching, in_hs, timeout_err;
  logic [7:0] sw_count;
  int errs = 0, checks = 0;

  clkswitch_req_ctrl dut (
    .lsclk_in(lsclk_in), .rst_b(rst_b), .hs_req(hs_req), .force_ls(force_ls),
    .lsclk_selected(lsclk_selected), .hsclk_selected(hsclk_selected),
    .hsclk_sel(hsclk_sel), .switching(switching), .in_hs(in_hs),
    .sw_count(sw_count), .timeout_err(timeout_err)
  );

  always #5 lsclk_in = ~lsclk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge lsclk_in);
      #1;
    end
  endtask

  // which: 0 = hsclk_sel high, 1 = in_hs high, 2 = back in LS_RUN
  task automatic wait_sig(input string tag, input int which);
    logic c = 1'b0;
    for (int n = 0; n < 50 && !c; n++) begin
      step();
      c = which == 0 ? hsclk_sel : which == 1 ? in_hs : (!switching && !in_hs && !hsclk_sel);
    end
    chk(tag, c, 1'b1);
  endtask

  initial begin
    rst_b = 1'b0; hs_req = 1'b0; force_ls = 1'b0;
    lsclk_selected = 1'b1; hsclk_selected = 1'b0;
    #7;
    chk("rst_outs", {hsclk_sel, switching, in_hs, timeout_err, sw_count}, 12'h000);
    #5;
    rst_b = 1'b1; hs_req = 1'b1;
    step(3);
    chk("hold_edge3", hsclk_sel, 1'b0);
    step();
    chk("req_edge4", {hsclk_sel, switching, in_hs}, 3'b110);
    step(2);
    chk("switching_req", switching, 1'b1);
    step();
    hsclk_selected = 1'b1; lsclk_selected = 1'b0;
    step();
    chk("ack_k1", in_hs, 1'b0);
    step();
    chk("ack_k2", {in_hs, switching}, 2'b01);
    step();
    chk("hs_run_k3", {in_hs, switching, hsclk_sel}, 3'b101);
    chk("sw_count1", sw_count, 8'd1);
    force_ls = 1'b1;
    step();
    force_ls = 1'b0;
    chk("force_exit", {hsclk_sel, switching, in_hs}, 3'b010);
    hsclk_selected = 1'b0; lsclk_selected = 1'b1;
    step(2);
    chk("req_ls_wait", switching, 1'b1);
    step();
    chk("ls_entry", {hsclk_sel, switching, in_hs}, 3'b000);
    step(3);
    chk("rereq_hold", hsclk_sel, 1'b0);
    step();
    chk("rereq", hsclk_sel, 1'b1);
    chk("sw_count_keep", sw_count, 8'd1);
    step(2);
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_sel", {hsclk_sel, switching}, 2'b00);
    chk("async_rst_cnt", sw_count, 8'd0);
    #2 rst_b = 1'b1;
    step(3);
    chk("post_rst_hold", hsclk_sel, 1'b0);
    step();
    chk("post_rst_req", hsclk_sel, 1'b1);
`ifdef CLKSW_TIMEOUT_EN
    step(14);
    chk("tmo_before", {hsclk_sel, timeout_err}, 2'b10);
    step();
    chk("tmo_hit", {hsclk_sel, timeout_err, switching}, 3'b011);
    step();
    chk("tmo_sticky", {timeout_err, switching}, 2'b10);
`else
    step(1000);
    chk("no_tmo", {hsclk_sel, timeout_err}, 2'b10);
`endif
    rst_b = 1'b0;
    #2 rst_b = 1'b1;
    chk("rst_clear", {timeout_err, sw_count}, 9'd0);
    for (int i = 1; i <= 256; i++) begin
      hs_req = 1'b1;
      wait_sig("rt_req", 0);
      hsclk_selected = 1'b1; lsclk_selected = 1'b0;
      wait_sig("rt_hs", 1);
      hs_req = 1'b0; hsclk_selected = 1'b0; lsclk_selected = 1'b1;
      wait_sig("rt_ls", 2);
      if (i == 255) chk("cnt255", sw_count, 8'd255);
    end
    chk("cnt_wrap", sw_count, 8'd0);
    hs_req = 1'b1;
    wait_sig("abort_req", 0);
    hsclk_selected = 1'b1;
    step(2);
    hs_req = 1'b0;
    step();
    chk("abort_state", {hsclk_sel, switching, in_hs}, 3'b010);
    chk("abort_cnt", sw_count, 8'd0);
    hsclk_selected = 1'b0;
    wait_sig("abort_ls", 2);
    chk("abort_cnt_end", sw_count, 8'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/clkswitch_req_ctrl.md
# clkswitch_req_ctrl

Low-speed-domain requester for the CPU clock switch. Running on the host bus clock `lsclk_in`, it decides when to ask for the high-speed CPU clock and drives `hsclk_sel` into the clock switch. It tracks the switch's `lsclk_selected`/`hsclk_selected` acknowledgements through a four-state handshake, and enforces a minimum low-speed dwell so the clock cannot thrash. An optional watchdog flags a switch that never acknowledges.

## Interface
- `LS_HOLD`, default 4: minimum `lsclk_in` cycles spent in LS_RUN before a new high-speed request; range 0-255.
- `TIMEOUT`, default 15: cycles allowed in a REQ state before timeout (only with `CLKSW_TIMEOUT_EN`); range 1-255.

- `lsclk_in` in 1: host bus clock; all state on posedge.
- `rst_b` in 1: reset, asynchronous, active-low.
- `hs_req` in 1: level request for fast clock, synchronous to `lsclk_in`.
- `force_ls` in 1: synchronous demand for low speed (host I/O access); overrides `hs_req`.
- `lsclk_selected` in 1: switch status, already in `lsclk_in` posedge domain.
- `hsclk_selected` in 1: switch status from CPU clock domain; asynchronous; internal 2-flop synchroniser gives `hs_ack`.
- `hsclk_sel` out 1: registered request to clock switch.
- `switching` out 1: high in REQ_HS or REQ_LS.
- `in_hs` out 1: high in HS_RUN.
- `sw_count` out 8: completed LS→HS switches; wraps 255→0.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- States: LS_RUN, REQ_HS, HS_RUN, REQ_LS. Reset state is LS_RUN.
- `hsclk_sel` is 1 in REQ_HS and HS_RUN, and 0 otherwise. It is decoded from registered state; there is no combinational path from inputs.
- Reset values:
  - State LS_RUN.
  - `hsclk_sel`, `switching`, `in_hs` = 0.
  - `sw_count` = 0, `timeout_err` = 0.
  - Hold counter = `LS_HOLD`, watchdog timer = 0.
  - Both synchroniser flops = 0.
- LS_RUN:
  - Hold counter decrements each cycle, saturating at 0.
  - Go to REQ_HS when `hs_req & !force_ls & hold==0 & lsclk_selected`.
- REQ_HS:
  - If `force_ls | !hs_req`, abort to REQ_LS; `sw_count` is unchanged.
  - Else if `hs_ack`, go to HS_RUN and increment `sw_count`.
  - Abort has priority over ack on the same edge.
- HS_RUN:
  - Go to REQ_LS on `force_ls | !hs_req | !hs_ack`.
  - A drop of `hs_ack` while in HS_RUN means the switch fell back; treat it as a normal exit.
- REQ_LS:
  - Go to LS_RUN when `lsclk_selected & !hs_ack`, reloading hold counter = `LS_HOLD`.
  - `hs_req` is ignored until LS_RUN is reached; an exit is never reversed mid-handshake.
- Watchdog timer:
  - Cleared on every state change.
  - Increments in REQ_HS/REQ_LS and saturates at 255.
- `LS_HOLD`=0: REQ_HS may be entered on the first LS_RUN cycle.

## Timing
- `hs_req` sampled high at edge N (LS_RUN, hold expired): state = REQ_HS and `hsclk_sel`=1 after edge N.
- `hsclk_selected` rising before edge M: `hs_ack`=1 after edge M+1, HS_RUN after edge M+2, `in_hs`=1 and `sw_count`+1 on that same edge.
- `force_ls`/`hs_req` drop at edge N in HS_RUN: `hsclk_sel`=0 after edge N.
- Return to LS: LS_RUN is entered on the first edge where `lsclk_selected`=1 and `hs_ack`=0. The earliest re-request is `LS_HOLD` cycles later.
- `rst_b` low at any time, including mid-handshake: `hsclk_sel` drops immediately and asynchronously, and all registers take their reset values.

## Configuration
- `CLKSW_TIMEOUT_EN` defined:
  - Timer reaching `TIMEOUT` in REQ_HS sets `timeout_err` and forces REQ_LS.
  - Timer reaching `TIMEOUT` in REQ_LS sets `timeout_err` and stays in REQ_LS waiting for the ack.
  - `timeout_err` clears only on reset.
- Undefined:
  - No watchdog logic; `timeout_err` is tied 0.
  - REQ states wait indefinitely.

## Test plan
- Reset, default params: all outputs 0; `hs_req`=1 with `lsclk_selected`=1 gives `hsclk_sel`=1 after edge 4 (hold 4→0 then request).
- Switch model raises `hsclk_selected` 3 cycles after `hsclk_sel` → `in_hs`=1 exactly 3 edges after the model's edge; `sw_count`=1; `switching` high throughout REQ_HS.
- `force_ls` pulse in HS_RUN → `hsclk_sel`=0 next edge; model drops `hsclk_selected` and raises `lsclk_selected` → LS_RUN. With `hs_req` held high, `hsclk_sel` is re-asserted no sooner than 4 cycles after LS_RUN entry.
- With `CLKSW_TIMEOUT_EN`, `TIMEOUT`=15, no ack → 15 cycles in REQ_HS then `timeout_err`=1 and `hsclk_sel`=0; without the macro, `hsclk_sel` stays 1 for 1000 cycles and `timeout_err`=0.
- `rst_b` asserted mid-REQ_HS → `hsclk_sel`=0 before the next `lsclk_in` edge; `sw_count`=0.
- 256 complete LS→HS→LS round trips → `sw_count` wraps to 0; an `hs_req` drop on the same edge as the ack gives REQ_LS with no increment.
